flag_register_unit: RTL and testbench
=====================================

Name: flag_register_unit

Overview:
- Holds the processor condition flags Z, N and C.
- Supplies the zf/nf/cf inputs consumed by the jump-decision logic.
- Updates the flags from the ALU and from SETC/CLRC.
- Clears a flag when a conditional jump on that flag is taken.
- Keeps a small shadow stack so flags are saved on interrupt entry and restored on RTI.

Parameters:
- DEPTH, 4, number of entries in the flag shadow stack (nested interrupt levels); power of two, at least 2.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- alu_we  input  3  per-flag ALU write enables, bit2=Z, bit1=N, bit0=C
- alu_zf  input  1  ALU zero result
- alu_nf  input  1  ALU negative result
- alu_cf  input  1  ALU carry result
- setc  input  1  SETC instruction strobe
- clrc  input  1  CLRC instruction strobe
- jc  input  1  jump-if-carry decode strobe
- jn  input  1  jump-if-negative decode strobe
- jz  input  1  jump-if-zero decode strobe
- int_save  input  1  interrupt entry: push flags
- rti_restore  input  1  RTI: pop flags
- zf  output  1  registered zero flag
- nf  output  1  registered negative flag
- cf  output  1  registered carry flag
- cond_taken  output  1  combinational: (jc&cf)|(jn&nf)|(jz&zf)
- stk_empty  output  1  shadow stack holds 0 entries
- stk_full  output  1  shadow stack holds DEPTH entries
- stk_err  output  1  sticky overflow/underflow/conflict error

Behaviour:
- Reset (rst_n=0, asynchronous):
  - zf=nf=cf=0.
  - Stack pointer=0, so stk_empty=1 and stk_full=0.
  - stk_err=0.
  - Stack contents are don't-care.
- Registers update only on the rising clk edge. cond_taken is purely combinational from the registered flags and the current jc/jn/jz; it is not registered.
- Per-flag next value, evaluated in priority order (first match wins), when no restore occurs:
  1. ALU write: alu_we bit set -> flag takes the ALU value.
  2. Carry only: setc -> 1. clrc -> 0. setc and clrc together -> cf unchanged and stk_err set.
  3. Consume: conditional jump on this flag with the flag currently 1 -> flag cleared to 0 (jz&zf clears Z, jn&nf clears N, jc&cf clears C).
  4. Otherwise hold.
- Restore:
  - rti_restore with stack not empty -> all three flags load the top entry and the pointer decrements.
  - Restore overrides every rule above in that cycle.
- Save:
  - int_save with stack not full -> the current registered {zf,nf,cf} (pre-update value of this cycle) is written at the pointer and the pointer increments.
  - Flag updates from the rules above still apply in the same cycle.
- Boundary conditions:
  - int_save when full: push ignored, pointer unchanged, stk_err set.
  - rti_restore when empty: flags follow the normal rules, pointer unchanged, stk_err set.
  - int_save and rti_restore together: both ignored, flags follow the normal rules, stk_err set.
  - stk_err clears only on reset.
- Stack is LIFO with no wrap-around; the pointer ranges 0..DEPTH.
- Latency:
  - Flag changes are visible on zf/nf/cf one cycle after the strobe.
  - cond_taken reflects strobes in the same cycle.
- Reset asserted mid-operation forces the reset state immediately, regardless of clk.

Test Plan:
- Reset: after reset, alu_we=3'b111 with z=1, n=0, c=1 -> next cycle zf=1, nf=0, cf=1.
- Consume: with zf=1, pulse jz=1 -> cond_taken=1 in the same cycle; next cycle zf=0 and cond_taken=0.
- Consume vs ALU: with cf=0, jc=1 -> cond_taken=0 and cf stays 0. With cf=1, jc=1 and alu_we[0]=1, alu_cf=1 in the same cycle -> cf=1 (ALU wins).
- Carry strobes: setc -> cf=1. clrc -> cf=0. setc and clrc together -> cf unchanged and stk_err=1.
- Save/restore: flags 3'b101, int_save, then ALU writes 3'b010, then rti_restore -> flags return to 3'b101 and stk_empty=1.
- Overflow/underflow: DEPTH=4 with 5 int_save pulses -> stk_full=1, 5th ignored, stk_err=1. After reset, rti_restore -> flags unchanged and stk_err=1.

Source files
------------

// File: rtl/flag_register_unit_if.sv
// Bus bundle between the core and the flag register unit.
interface flag_register_unit_if;
  logic [2:0] alu_we;
  logic       alu_zf;
  logic       alu_nf;
  logic       alu_cf;
  logic       setc;
  logic       clrc;
  logic       jc;
  logic       jn;
  logic       jz;
  logic       int_save;
  logic       rti_restore;
  logic       zf;
  logic       nf;
  logic       cf;
  logic       cond_taken;
  logic       stk_empty;
  logic       stk_full;
  logic       stk_err;

  modport master (
    output alu_we, alu_zf, alu_nf, alu_cf, setc, clrc, jc, jn, jz,
           int_save, rti_restore,
    input  zf, nf, cf, cond_taken, stk_empty, stk_full, stk_err
  );

  modport slave (
    input  alu_we, alu_zf, alu_nf, alu_cf, setc, clrc, jc, jn, jz,
           int_save, rti_restore,
    output zf, nf, cf, cond_taken, stk_empty, stk_full, stk_err
  );
endinterface

// File: rtl/flag_register_unit.sv
// Condition flag register (Z/N/C) with jump-consume clearing and an
// interrupt shadow stack for save on entry / restore on RTI.
module flag_register_unit #(
  parameter int unsigned DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  flag_register_unit_if.slave  bus_if
);

  localparam int unsigned PTR_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  // Flag vector ordering: bit2=Z, bit1=N, bit0=C
  logic [2:0]       flags_q, flags_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             err_q, err_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             push_c;
  logic [2:0]       stk_q [DEPTH];
  logic [2:0]       jump_c;
  logic [2:0]       alu_c;
  logic [2:0]       top_c;

  assign jump_c = {bus_if.jz, bus_if.jn, bus_if.jc};
  assign alu_c  = {bus_if.alu_zf, bus_if.alu_nf, bus_if.alu_cf};
  assign top_c  = stk_q[IDX_W'(ptr_q - PTR_W'(1))];

  // Flag update priority, stack pointer movement and sticky error
  always_comb begin
    flags_d = flags_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    push_c  = 1'b0;

    // Z and N: ALU write, else consume on taken jump
    for (int i = 1; i < 3; i++) begin
      if (bus_if.alu_we[i]) begin
        flags_d[i] = alu_c[i];
      end else if (jump_c[i] && flags_q[i]) begin
        flags_d[i] = 1'b0;
      end
    end

    // C: ALU write, else SETC/CLRC, else consume
    if (bus_if.alu_we[0]) begin
      flags_d[0] = alu_c[0];
    end else if (bus_if.setc || bus_if.clrc) begin
      if (!(bus_if.setc && bus_if.clrc)) begin
        flags_d[0] = bus_if.setc;
      end
    end else if (jump_c[0] && flags_q[0]) begin
      flags_d[0] = 1'b0;
    end

    if (bus_if.setc && bus_if.clrc) begin
      err_d = 1'b1;
    end

    // Simultaneous save and restore is ambiguous: drop both
    if (bus_if.int_save && bus_if.rti_restore) begin
      err_d = 1'b1;
    end else if (bus_if.rti_restore) begin
      if (empty_q) begin
        err_d = 1'b1;
      end else begin
        flags_d = top_c;
        ptr_d   = ptr_q - PTR_W'(1);
      end
    end else if (bus_if.int_save) begin
      if (full_q) begin
        err_d = 1'b1;
      end else begin
        push_c = 1'b1;
        ptr_d  = ptr_q + PTR_W'(1);
      end
    end

    empty_d = (ptr_d == PTR_W'(0));
    full_d  = (ptr_d == PTR_W'(DEPTH));
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 3'b000;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      flags_q <= flags_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  // Shadow stack storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (push_c) begin
      stk_q[IDX_W'(ptr_q)] <= flags_q;
    end
  end

  assign bus_if.zf         = flags_q[2];
  assign bus_if.nf         = flags_q[1];
  assign bus_if.cf         = flags_q[0];
  assign bus_if.cond_taken = |(jump_c & flags_q);
  assign bus_if.stk_empty  = empty_q;
  assign bus_if.stk_full   = full_q;
  assign bus_if.stk_err    = err_q;

endmodule

// File: tb/tb_flag_register_unit.sv
// Bench for flag_register_unit: directed plan steps plus random traffic
// checked against a queue-based reference model.
module tb_flag_register_unit;

  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst_n;

  flag_register_unit_if bus_if ();

  flag_register_unit #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: flags as {Z,N,C}, stack as a queue
  bit [2:0] m_f;
  bit [2:0] m_q [$];
  bit       m_err;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_flags"}, 8'({bus_if.zf, bus_if.nf, bus_if.cf}), 8'(m_f));
    chk({tag, "_empty"}, 8'(bus_if.stk_empty), 8'(m_q.size() == 0));
    chk({tag, "_full"},  8'(bus_if.stk_full),  8'(m_q.size() == DEPTH));
    chk({tag, "_err"},   8'(bus_if.stk_err),   8'(m_err));
  endtask

  task automatic drive(input logic [2:0] we, input logic [2:0] alu,
                       input logic s, input logic c,
                       input logic j_c, input logic j_n, input logic j_z,
                       input logic sv, input logic rt);
    bus_if.alu_we      = we;
    bus_if.alu_zf      = alu[2];
    bus_if.alu_nf      = alu[1];
    bus_if.alu_cf      = alu[0];
    bus_if.setc        = s;
    bus_if.clrc        = c;
    bus_if.jc          = j_c;
    bus_if.jn          = j_n;
    bus_if.jz          = j_z;
    bus_if.int_save    = sv;
    bus_if.rti_restore = rt;
  endtask

  // Model of one clock edge, written straight from the flag rules
  task automatic model_edge(input logic [2:0] we, input logic [2:0] alu,
                            input logic s, input logic c,
                            input logic [2:0] jmp, input logic sv, input logic rt);
    bit [2:0] nxt;
    nxt = m_f;
    for (int i = 0; i < 3; i++) begin
      if (we[i])                       nxt[i] = alu[i];
      else if (i == 0 && (s || c))     nxt[i] = (s && c) ? m_f[i] : s;
      else if (jmp[i] && m_f[i])       nxt[i] = 1'b0;
    end
    if (s && c) m_err = 1'b1;
    if (sv && rt) begin
      m_err = 1'b1;
    end else if (rt) begin
      if (m_q.size() > 0) nxt = m_q.pop_back();
      else                m_err = 1'b1;
    end else if (sv) begin
      if (m_q.size() < DEPTH) m_q.push_back(m_f);
      else                    m_err = 1'b1;
    end
    m_f = nxt;
  endtask

  // One cycle: drive, check cond_taken combinationally, clock, check state
  task automatic step(input logic [2:0] we, input logic [2:0] alu,
                      input logic s, input logic c,
                      input logic j_c, input logic j_n, input logic j_z,
                      input logic sv, input logic rt, input string tag);
    logic [2:0] jmp;
    jmp = {j_z, j_n, j_c};
    drive(we, alu, s, c, j_c, j_n, j_z, sv, rt);
    #1;
    chk({tag, "_cond"}, 8'(bus_if.cond_taken), 8'(|(jmp & m_f)));
    @(posedge clk);
    model_edge(we, alu, s, c, jmp, sv, rt);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  // Reset asserted between edges; state must clear without a clock edge
  task automatic do_reset(input string tag);
    drive(3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    m_f = 3'b000;
    m_q.delete();
    m_err = 1'b0;
    check_all(tag);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    m_f = 3'b000;
    m_err = 1'b0;
    @(posedge clk);
    #1;
    do_reset("reset");

    // ALU write after reset
    step(3'b111, 3'b101, 0, 0, 0, 0, 0, 0, 0, "alu_all");
    chk("alu_all_exp", 8'({bus_if.zf, bus_if.nf, bus_if.cf}), 8'h5);

    // Consume Z via taken jz; second jz no longer taken
    step(3'b000, 3'b000, 0, 0, 0, 0, 1, 0, 0, "jz_take");
    step(3'b000, 3'b000, 0, 0, 0, 0, 1, 0, 0, "jz_after");
    chk("jz_cleared", 8'(bus_if.zf), 8'h0);

    // Consume vs ALU on carry
    step(3'b000, 3'b000, 0, 1, 0, 0, 0, 0, 0, "clrc");
    step(3'b000, 3'b000, 0, 0, 1, 0, 0, 0, 0, "jc_nottaken");
    step(3'b000, 3'b000, 1, 0, 0, 0, 0, 0, 0, "setc");
    step(3'b001, 3'b001, 0, 0, 1, 0, 0, 0, 0, "jc_vs_alu");
    chk("alu_wins", 8'(bus_if.cf), 8'h1);

    // Carry strobes
    step(3'b000, 3'b000, 0, 1, 0, 0, 0, 0, 0, "clrc2");
    step(3'b000, 3'b000, 1, 1, 0, 0, 0, 0, 0, "setc_clrc");
    chk("setc_clrc_err", 8'(bus_if.stk_err), 8'h1);

    // Save / restore round trip
    do_reset("reset_sr");
    step(3'b111, 3'b101, 0, 0, 0, 0, 0, 0, 0, "sr_load");
    step(3'b000, 3'b000, 0, 0, 0, 0, 0, 1, 0, "sr_save");
    step(3'b111, 3'b010, 0, 0, 0, 0, 0, 0, 0, "sr_alu");
    step(3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 1, "sr_rti");
    chk("sr_restored", 8'({bus_if.zf, bus_if.nf, bus_if.cf}), 8'h5);
    chk("sr_empty", 8'(bus_if.stk_empty), 8'h1);

    // Overflow: fifth save ignored
    for (int i = 0; i < 5; i++) begin
      step(3'b111, 3'(i), 0, 0, 0, 0, 0, 1, 0, "ovf_save");
    end
    chk("ovf_full", 8'(bus_if.stk_full), 8'h1);
    chk("ovf_err", 8'(bus_if.stk_err), 8'h1);
    for (int i = 0; i < 4; i++) begin
      step(3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 1, "ovf_pop");
    end

    // Underflow after reset
    do_reset("reset_unf");
    step(3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 1, "unf_rti");
    chk("unf_err", 8'(bus_if.stk_err), 8'h1);
    chk("unf_flags", 8'({bus_if.zf, bus_if.nf, bus_if.cf}), 8'h0);

    // Save and restore together
    do_reset("reset_both");
    step(3'b111, 3'b011, 0, 0, 0, 0, 0, 0, 0, "both_load");
    step(3'b000, 3'b000, 0, 0, 0, 1, 0, 1, 1, "both");
    idle("both_idle");

    // Mid-operation reset with nonzero state
    step(3'b111, 3'b111, 0, 0, 0, 0, 0, 1, 0, "mid_load");
    do_reset("mid_reset");

    // Randomised traffic, periodically reset so errors stay informative
    for (int n = 0; n < 600; n++) begin
      if (n % 60 == 59) begin
        do_reset("rnd_reset");
      end else begin
        step(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
             "rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
